serial_subtractor: RTL and testbench

//  Bit-serial N-bit subtractor with borrow-in/out: diff = a - b - bin, one bit per clock, LSB first.

---
 rtl/serial_subtractor_if.sv | 30 +++
 rtl/serial_subtractor.sv | 100 ++++++++++
 tb/tb_serial_subtractor.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/done handshake bundle between a sequencer and the bit-serial subtractor.
// The ovf signal exists only when SUB_OVF_EN is defined.
interface serial_subtractor_if #(parameter int W = 4);
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SUB_OVF_EN
    logic         ovf;
`endif
    modport master (
        output start, a, b, bin,
        input  ready, busy, done, diff, bout
`ifdef SUB_OVF_EN
        , input ovf
`endif
    );
    modport slave (
        input  start, a, b, bin,
        output ready, busy, done, diff, bout
`ifdef SUB_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, one bit per clock LSB first, behind a start/done handshake.
// Define SUB_OVF_EN to add the registered signed-overflow output.
module serial_subtractor #(
    parameter int W = 4
) (
    input logic               clk,
    input logic               rst_n,
    serial_subtractor_if.slave s
);
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        r_state;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-2:0]  r_sh;
    logic [CW-1:0] r_count;
    logic          r_borrow;
    logic          r_ready;
    logic          r_busy;
    logic          r_done;
    logic [W-1:0]  r_diff;
    logic          r_bout;

    logic          w_ai;
    logic          w_bi;
    logic          w_d;
    logic          w_borrow;
    logic          w_last;
    logic [W-1:0]  w_sh;

    // Operands stay parallel and are indexed by the bit counter; only the result shifts.
    assign w_ai     = r_a[r_count];
    assign w_bi     = r_b[r_count];
    assign w_d      = w_ai ^ w_bi ^ r_borrow;
    assign w_borrow = (~w_ai & w_bi) | (~w_ai & r_borrow) | (w_bi & r_borrow);
    assign w_sh     = {w_d, r_sh};
    assign w_last   = r_count == CW'(W - 1);

`ifdef SUB_OVF_EN
    logic r_ovf;
    logic w_ovf;
    assign w_ovf = (r_a[W-1] ^ r_b[W-1]) & (w_d ^ r_a[W-1]);
    assign s.ovf = r_ovf;
`endif

    assign s.ready = r_ready;
    assign s.busy  = r_busy;
    assign s.done  = r_done;
    assign s.diff  = r_diff;
    assign s.bout  = r_bout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_sh     <= '0;
            r_count  <= '0;
            r_borrow <= 1'b0;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
`ifdef SUB_OVF_EN
            r_ovf    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (r_state == RUN) begin
                r_borrow <= w_borrow;
                r_sh     <= w_sh[W-1:1];
                r_count  <= w_last ? '0 : r_count + 1'b1;
                if (w_last) begin
                    r_state <= DONE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_diff  <= w_sh;
                    r_bout  <= w_borrow;
`ifdef SUB_OVF_EN
                    r_ovf   <= w_ovf;
`endif
                end
            end else if (s.start) begin
                r_state  <= RUN;
                r_a      <= s.a;
                r_b      <= s.b;
                r_borrow <= s.bin;
                r_count  <= '0;
                r_ready  <= 1'b0;
                r_busy   <= 1'b1;
            end else begin
                r_state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random checks of serial_subtractor (W=4) against an arithmetic model.
// Define SUB_OVF_EN for both files to also check ovf.
module tb_serial_subtractor;
    localparam int W = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    serial_subtractor_if #(.W(W)) ifc();
    serial_subtractor #(.W(W)) dut (.clk(clk), .rst_n(rst_n), .s(ifc.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        int           r;
        int           sr;
        int           n;
        logic [W-1:0] ed;
        logic [W-1:0] held;
        logic         eb;
        logic         eo;
        r  = int'(a) - int'(b) - int'(bin);
        ed = W'(r);
        eb = r < 0;
        sr = int'($signed(a)) - int'($signed(b)) - int'(bin);
        eo = (sr < -(2 ** (W - 1))) || (sr > 2 ** (W - 1) - 1);
        @(negedge clk);
        chk("ready_idle", ifc.ready, 1);
        ifc.start = 1'b1; ifc.a = a; ifc.b = b; ifc.bin = bin;
        held = ifc.diff;
        @(negedge clk);
        ifc.start = 1'b0; ifc.a = W'($urandom); ifc.b = W'($urandom); ifc.bin = 1'($urandom);
        n = 1;
        while (!ifc.done && n < 3 * W) begin
            chk("busy_run", ifc.busy, 1);
            chk("diff_stable_run", ifc.diff, held);
            @(negedge clk);
            n++;
        end
        chk("latency", n, W + 1);
        chk("diff", ifc.diff, ed);
        chk("bout", ifc.bout, eb);
`ifdef SUB_OVF_EN
        chk("ovf", ifc.ovf, eo);
`endif
        chk("ready_done", ifc.ready, 1);
        chk("busy_done", ifc.busy, 0);
        @(negedge clk);
        chk("done_single", ifc.done, 0);
        chk("diff_held", ifc.diff, ed);
        chk("bout_held", ifc.bout, eb);
    endtask

    initial begin
        ifc.start = 1'b0; ifc.a = '0; ifc.b = '0; ifc.bin = 1'b0;
        #12;
        chk("rst_ready", ifc.ready, 1);
        chk("rst_busy", ifc.busy, 0);
        chk("rst_done", ifc.done, 0);
        chk("rst_diff", ifc.diff, 0);
        chk("rst_bout", ifc.bout, 0);
`ifdef SUB_OVF_EN
        chk("rst_ovf", ifc.ovf, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        run_op(4'd9, 4'd3, 1'b0);
        chk("d9m3_diff", ifc.diff, 6);
        chk("d9m3_bout", ifc.bout, 0);
        run_op(4'd3, 4'd9, 1'b0);
        chk("d3m9_diff", ifc.diff, 4'hA);
        chk("d3m9_bout", ifc.bout, 1);
        run_op(4'd0, 4'd0, 1'b1);
        chk("wrap_diff", ifc.diff, 4'hF);
        chk("wrap_bout", ifc.bout, 1);

        // start pulsed while busy must be ignored
        @(negedge clk);
        ifc.start = 1'b1; ifc.a = 4'd9; ifc.b = 4'd3; ifc.bin = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("ign_done", ifc.done, k == 5);
            if (k == 1) ifc.start = 1'b0;
            if (k == 2) begin ifc.start = 1'b1; ifc.a = 4'hF; ifc.b = 4'hF; end
            if (k == 3) ifc.start = 1'b0;
        end
        chk("ign_diff", ifc.diff, 6);
        chk("ign_bout", ifc.bout, 0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("ign_no_extra_done", ifc.done, 0);
            chk("ign_diff_hold", ifc.diff, 6);
        end

        // start held high: back-to-back ops every W+1 cycles
        @(negedge clk);
        ifc.start = 1'b1; ifc.a = 4'd5; ifc.b = 4'd2; ifc.bin = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            chk("b2b_done", ifc.done, (k % 5) == 0);
            if ((k % 5) == 0) chk("b2b_diff", ifc.diff, 3);
        end
        ifc.start = 1'b0;
        @(negedge clk);
        chk("b2b_idle_done", ifc.done, 0);
        chk("b2b_idle_ready", ifc.ready, 1);

        // asynchronous reset in the middle of an operation
        run_op(4'd9, 4'd3, 1'b0);
        @(negedge clk);
        ifc.start = 1'b1; ifc.a = 4'd3; ifc.b = 4'd9;
        @(negedge clk);
        ifc.start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_diff", ifc.diff, 0);
        chk("arst_bout", ifc.bout, 0);
        chk("arst_busy", ifc.busy, 0);
        chk("arst_ready", ifc.ready, 1);
        chk("arst_done", ifc.done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("arst_no_done", ifc.done, 0);
        end
        run_op(4'd3, 4'd9, 1'b0);
        chk("post_rst_diff", ifc.diff, 4'hA);

`ifdef SUB_OVF_EN
        run_op(4'd8, 4'd1, 1'b0);
        chk("ovf_8m1_diff", ifc.diff, 7);
        chk("ovf_8m1", ifc.ovf, 1);
        run_op(4'd7, 4'd1, 1'b0);
        chk("ovf_7m1_diff", ifc.diff, 6);
        chk("ovf_7m1", ifc.ovf, 0);
        repeat (1000) run_op(W'($urandom), W'($urandom), 1'($urandom));
`else
        repeat (300) run_op(W'($urandom), W'($urandom), 1'($urandom));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
